alu8_arbiter: RTL and testbench
===============================

ALU8_ARBITER -- requirements
Module: alu8_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, operand/result width in bits.
REQ-002 Parameter OP_W, default 3, opcode width in bits.
REQ-003 Port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  in  1  reset; asynchronous, active-high.
REQ-005 Port req_valid  in  2  bit n: requester n presents an operation.
REQ-006 Port req_ready  out  2  bit n: requester n's operation accepted this cycle.
REQ-007 Port req_op  in  2*OP_W  opcode of requester n at [OP_W*n +: OP_W].
REQ-008 Port req_a  in  2*DATA_W  operand A of requester n at [DATA_W*n +: DATA_W].
REQ-009 Port req_b  in  2*DATA_W  operand B of requester n at [DATA_W*n +: DATA_W].
REQ-010 Port rsp_valid  out  1  result available.
REQ-011 Port rsp_ready  in  1  consumer takes result when high with rsp_valid.
REQ-012 Port rsp_id  out  1  index of requester owning the result.
REQ-013 Port rsp_r  out  DATA_W  result.

Function
REQ-014 Opcodes SHALL be: 0 A+B, 1 A-B, 2 ~A, 3 ~(A&B), 4 ~(A|B), 5 A&B, 6 A|B, 7 A^B; add/sub modulo 2^DATA_W.
REQ-015 FSM states SHALL be IDLE, EXEC, RESP; transitions IDLE->EXEC on grant, EXEC->RESP unconditionally, RESP->IDLE on rsp_valid&&rsp_ready.
REQ-016 In IDLE, with any req_valid high, grant SHALL go to one requester: the sole valid one, or, if both valid, the one indicated by the round-robin pointer.
REQ-017 req_ready SHALL be combinational, one-hot, high only in IDLE for the granted requester; both bits zero in EXEC and RESP.
REQ-018 On grant, op, A, B and requester index SHALL be registered; later changes on req_* inputs SHALL not affect the in-flight operation.
REQ-019 In EXEC the ALU SHALL evaluate the registered operands; result latched into rsp_r at EXEC end.
REQ-020 rsp_valid SHALL rise two cycles after the accept cycle (accept at edge T, rsp_valid high after edge T+2).
REQ-021 While rsp_valid && !rsp_ready, rsp_r, rsp_id (and flags) SHALL hold stable; no new grant.
REQ-022 Round-robin pointer SHALL update on each grant to point at the non-granted requester.
REQ-023 Maximum throughput SHALL be one operation per 3 cycles; a requester withdrawing req_valid before grant SHALL not be served.

Reset
REQ-024 On rst high, SHALL immediately: state IDLE, rsp_valid 0, rsp_r 0, rsp_id 0, pointer 0 (requester 0 wins first tie), req_ready 0 while rst asserted.
REQ-025 Reset during EXEC or RESP SHALL discard the in-flight operation; no response issued after release.

Configuration
REQ-026 Macro ALU8_ARBITER_FLAGS_EN defined: outputs rsp_zero (1 when rsp_r==0) and rsp_carry (carry-out for op 0, borrow for op 1, 0 otherwise) SHALL exist, registered with rsp_r, reset 0, held under REQ-021.
REQ-027 Macro undefined: rsp_zero and rsp_carry ports and their logic SHALL be absent; all other behaviour unchanged.

Structure
REQ-028 Package alu8_pkg SHALL hold opcode enumeration, FSM state typedef, DATA_W/OP_W defaults.
REQ-029 Combinational datapath SHALL be sub-module alu8_core (A, B, op -> R, carry), instantiated once.

Verification
REQ-030 Reset, then req_valid=01, op=0, A=8'hF0, B=8'h20 -> req_ready=01 that cycle, rsp_valid two cycles later, rsp_r=8'h10, rsp_id=0, rsp_carry=1 when flags enabled.
REQ-031 Both valid continuously, op=1, A0=5,B0=7, A1=9,B1=3 -> responses alternate id 0 (8'hFE, carry=1), id 1 (8'h06), id 0 ...
REQ-032 rsp_ready held 0 for 5 cycles after rsp_valid, op=7, A=8'hAA, B=8'hFF -> rsp_r=8'h55 stable, req_ready=00 throughout, release completes in one cycle.
REQ-033 Sweep all 8 opcodes with A=8'h0F, B=8'h33 -> rsp_r matches REQ-014; op 5 with A=8'h0F,B=8'hF0 gives rsp_r=0, rsp_zero=1.
REQ-034 Assert rst during EXEC -> rsp_valid stays 0, no response for that operation; next request after release served normally with id 0 priority on tie.

Source files
------------

// File: rtl/alu8_pkg.sv
// Shared types and default widths for the two-requester ALU arbiter.
// Used by every file of alu8_arbiter, including the optional ALU8_ARBITER_FLAGS_EN outputs.
package alu8_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int OP_W_DEF   = 3;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_NOTA = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_AND  = 3'd5,
        OP_OR   = 3'd6,
        OP_XOR  = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu8_core.sv
// Purely combinational ALU: result plus carry-out (add) or borrow (sub).
// The carry bit is consumed by the top only when ALU8_ARBITER_FLAGS_EN is defined.
module alu8_core
    import alu8_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OP_W   = OP_W_DEF
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] r,
    output logic              carry
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    // The extra top bit of diff is set exactly when a < b, i.e. the borrow.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        // NOTE: outputs get a default before the case so no path leaves them unassigned (no latch).
        r     = '0;
        carry = 1'b0;
        case (op)
            OP_ADD: begin
                r     = sum[DATA_W-1:0];
                carry = sum[DATA_W];
            end
            OP_SUB: begin
                r     = diff[DATA_W-1:0];
                carry = diff[DATA_W];
            end
            OP_NOTA: r = ~a;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = '0;
        endcase
    end

endmodule

// File: rtl/alu8_arbiter.sv
// Round-robin arbiter feeding one ALU: IDLE (grant) -> EXEC -> RESP (hold until taken).
// Define ALU8_ARBITER_FLAGS_EN to add the registered rsp_zero / rsp_carry outputs.
module alu8_arbiter
    import alu8_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OP_W   = OP_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [2*OP_W-1:0]   req_op,
    input  logic [2*DATA_W-1:0] req_a,
    input  logic [2*DATA_W-1:0] req_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [DATA_W-1:0]   rsp_r
`ifdef ALU8_ARBITER_FLAGS_EN
    ,
    output logic                rsp_zero,
    output logic                rsp_carry
`endif
);

    state_e              state_q, state_d;
    logic                ptr_q, ptr_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic                id_q, id_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]   rsp_r_q, rsp_r_d;

    logic                grant;
    logic                gnt_id;
    logic [DATA_W-1:0]   alu_r;
    logic                alu_carry;

    // The pointer only matters on a tie; a lone requester always wins.
    assign gnt_id    = (req_valid == 2'b11) ? ptr_q : req_valid[1];
    assign grant     = (state_q == ST_IDLE) && (|req_valid) && !rst;
    assign req_ready = grant ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;

    alu8_core #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W)
    ) u_core (
        .a     (a_q),
        .b     (b_q),
        .op    (op_q),
        .r     (alu_r),
        .carry (alu_carry)
    );

`ifdef ALU8_ARBITER_FLAGS_EN
    logic zero_q, zero_d;
    logic carry_q, carry_d;
`else
    logic unused_carry;
    assign unused_carry = alu_carry;
`endif

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_r_d     = rsp_r_q;
`ifdef ALU8_ARBITER_FLAGS_EN
        zero_d      = zero_q;
        carry_d     = carry_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    state_d = ST_EXEC;
                    ptr_d   = ~gnt_id;
                    id_d    = gnt_id;
                    op_d    = gnt_id ? req_op[2*OP_W-1:OP_W]   : req_op[OP_W-1:0];
                    a_d     = gnt_id ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
                    b_d     = gnt_id ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
                end
            end
            ST_EXEC: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_id_d    = id_q;
                rsp_r_d     = alu_r;
`ifdef ALU8_ARBITER_FLAGS_EN
                zero_d      = (alu_r == '0);
                carry_d     = alu_carry;
`endif
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_r_q     <= '0;
`ifdef ALU8_ARBITER_FLAGS_EN
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_r_q     <= rsp_r_d;
`ifdef ALU8_ARBITER_FLAGS_EN
            zero_q      <= zero_d;
            carry_q     <= carry_d;
`endif
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_r     = rsp_r_q;
`ifdef ALU8_ARBITER_FLAGS_EN
    assign rsp_zero  = zero_q;
    assign rsp_carry = carry_q;
`endif

endmodule

// File: tb/tb_alu8_arbiter.sv
// Self-checking bench for alu8_arbiter: vector table plus hand-written corner sequences,
// with a response scoreboard; flag outputs are checked when ALU8_ARBITER_FLAGS_EN is defined.
module tb_alu8_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [5:0]  req_op = '0;
    logic [15:0] req_a = '0;
    logic [15:0] req_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        rsp_id;
    logic [7:0]  rsp_r;
`ifdef ALU8_ARBITER_FLAGS_EN
    logic        rsp_zero;
    logic        rsp_carry;
`endif

    alu8_arbiter #(
        .DATA_W (8),
        .OP_W   (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_r     (rsp_r)
`ifdef ALU8_ARBITER_FLAGS_EN
        ,
        .rsp_zero  (rsp_zero),
        .rsp_carry (rsp_carry)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       id;
        logic [7:0] r;
        logic       c;
        logic       z;
    } exp_t;

    typedef struct {
        logic       id;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic       c;
        logic       z;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[13];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   cyc          = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk_exp(input logic id, input logic [7:0] r, input logic c,
                                    input logic z);
        exp_t e;
        e.id = id;
        e.r  = r;
        e.c  = c;
        e.z  = z;
        return e;
    endfunction

    // Response monitor: every accepted response must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            exp_t e;
            check("sb_has_entry", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("rsp_id", 32'(rsp_id), 32'(e.id));
                check("rsp_r", 32'(rsp_r), 32'(e.r));
`ifdef ALU8_ARBITER_FLAGS_EN
                check("rsp_carry", 32'(rsp_carry), 32'(e.c));
                check("rsp_zero", 32'(rsp_zero), 32'(e.z));
`endif
            end
        end
    end

    task automatic drive_req(input logic id, input logic [2:0] op, input logic [7:0] a,
                             input logic [7:0] b);
        if (id) begin
            req_op[5:3] = op;
            req_a[15:8] = a;
            req_b[15:8] = b;
        end else begin
            req_op[2:0] = op;
            req_a[7:0]  = a;
            req_b[7:0]  = b;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst       = 1'b1;
        req_valid = 2'b11;
        @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_r", 32'(rsp_r), 32'd0);
        check("reset_rsp_id", 32'(rsp_id), 32'd0);
`ifdef ALU8_ARBITER_FLAGS_EN
        check("reset_rsp_zero", 32'(rsp_zero), 32'd0);
        check("reset_rsp_carry", 32'(rsp_carry), 32'd0);
`endif
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        rst       = 1'b0;
    endtask

    // Single request with rsp_ready high: grant that cycle, response two cycles later.
    task automatic run_op(input vec_t v);
        logic [1:0] exp_rdy;
        exp_rdy = v.id ? 2'b10 : 2'b01;
        @(posedge clk);
        #1;
        req_valid = exp_rdy;
        drive_req(v.id, v.op, v.a, v.b);
        sb_q.push_back(mk_exp(v.id, v.r, v.c, v.z));
        @(negedge clk);
        check("grant_ready", 32'(req_ready), 32'(exp_rdy));
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        req_op    = 6'($urandom);
        req_a     = 16'($urandom);
        req_b     = 16'($urandom);
        @(negedge clk);
        check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        check("exec_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("resp_rsp_valid", 32'(rsp_valid), 32'd1);
        @(posedge clk);
        #1;
        check("sb_drained", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        int grants;
        int last_cyc;
        logic exp_id;

        //            id    op    a      b      r      c     z
        vecs[0]  = '{1'b0, 3'd0, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 3'd0, 8'h0F, 8'h33, 8'h42, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 3'd1, 8'h0F, 8'h33, 8'hDC, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 3'd2, 8'h0F, 8'h33, 8'hF0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 3'd3, 8'h0F, 8'h33, 8'hFC, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 3'd4, 8'h0F, 8'h33, 8'hC0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 3'd5, 8'h0F, 8'h33, 8'h03, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 3'd6, 8'h0F, 8'h33, 8'h3F, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 3'd7, 8'h0F, 8'h33, 8'h3C, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 3'd5, 8'h0F, 8'hF0, 8'h00, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 3'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 3'd1, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 3'd1, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1};

        do_reset();
        for (int i = 0; i < 13; i++) run_op(vecs[i]);

        // Both requesters valid continuously: strict alternation starting at 0, one op per 3 cycles.
        do_reset();
        req_op = {3'd1, 3'd1};
        req_a  = {8'd9, 8'd5};
        req_b  = {8'd3, 8'd7};
        for (int k = 0; k < 2; k++) begin
            sb_q.push_back(mk_exp(1'b0, 8'hFE, 1'b1, 1'b0));
            sb_q.push_back(mk_exp(1'b1, 8'h06, 1'b0, 1'b0));
        end
        @(posedge clk);
        #1;
        req_valid = 2'b11;
        grants    = 0;
        last_cyc  = 0;
        exp_id    = 1'b0;
        for (int k = 0; k < 40 && grants < 4; k++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                check("rr_ready", 32'(req_ready), exp_id ? 32'd2 : 32'd1);
                if (grants > 0) check("rr_spacing", 32'(cyc - last_cyc), 32'd3);
                last_cyc = cyc;
                grants++;
                exp_id   = ~exp_id;
            end
        end
        check("rr_grants", 32'(grants), 32'd4);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(posedge clk);
        #1;
        check("rr_drained", 32'(sb_q.size()), 32'd0);

        // Consumer stall: result held, no grant, withdrawn request never served.
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        req_valid = 2'b01;
        drive_req(1'b0, 3'd7, 8'hAA, 8'hFF);
        sb_q.push_back(mk_exp(1'b0, 8'h55, 1'b0, 1'b0));
        @(negedge clk);
        check("stall_grant", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        check("stall_rsp_valid_rise", 32'(rsp_valid), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 2'b11;
        req_a     = 16'h1234;
        req_b     = 16'h5678;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            check("stall_rsp_r", 32'(rsp_r), 32'h55);
            check("stall_rsp_id", 32'(rsp_id), 32'd0);
            check("stall_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall_drained", 32'(sb_q.size()), 32'd0);
        @(negedge clk);
        check("release_one_cycle", 32'(rsp_valid), 32'd0);
        check("withdrawn_not_served", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("withdrawn_no_rsp", 32'(rsp_valid), 32'd0);

        // Reset in EXEC: operation discarded, then id 0 wins the first tie.
        @(posedge clk);
        #1;
        req_valid = 2'b01;
        drive_req(1'b0, 3'd0, 8'h11, 8'h22);
        @(negedge clk);
        check("rst_exec_grant", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 2'b11;
        rst       = 1'b1;
        #1;
        check("rst_async_rsp_r", 32'(rsp_r), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        rst       = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        req_op    = {3'd0, 3'd0};
        req_a     = {8'h40, 8'h01};
        req_b     = {8'h40, 8'h02};
        req_valid = 2'b11;
        sb_q.push_back(mk_exp(1'b0, 8'h03, 1'b0, 1'b0));
        @(negedge clk);
        check("rst_tie_id0", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        check("rst_next_rsp_valid", 32'(rsp_valid), 32'd1);
        @(posedge clk);
        #1;
        check("final_drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed",
                 tests_run, tests_failed);
        $fatal(1, "watchdog expired");
    end

endmodule
